// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: the RAM handshake status reported back to requesters.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the two CPU instruction ports and the shared RAM read port.
interface imem_arbiter_if;
    import cpu_types_pkg::*;

    logic [1:0]  iREN;
    logic [31:0] iaddr0;
    logic [31:0] iaddr1;
    logic [1:0]  iwait;
    logic [31:0] iload0;
    logic [31:0] iload1;
    logic        ramREN;
    logic [31:0] ramaddr;
    logic [31:0] ramload;
    ramstate_t   ramstate;
    logic [7:0]  err_count;

    // Arbiter side
    modport slave (
        input  iREN, iaddr0, iaddr1, ramload, ramstate,
        output iwait, iload0, iload1, ramREN, ramaddr, err_count
    );

    // CPU/RAM side
    modport master (
        output iREN, iaddr0, iaddr1, ramload, ramstate,
        input  iwait, iload0, iload1, ramREN, ramaddr, err_count
    );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one instruction RAM read port between two CPUs,
// with abort on request drop/redirect, RAM error and timeout.
module imem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic            CLK,
    input  logic            RST,
    imem_arbiter_if.slave   bus
);

    localparam int unsigned TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            r_state;
    logic              r_g;
    logic              r_lg;
    logic [31:0]       r_la;
    logic [TC_W-1:0]   r_tc;
    logic [31:0]       r_iload0;
    logic [31:0]       r_iload1;
    logic [7:0]        r_err;
    logic [1:0]        r_iwait;
    logic              r_ramren;

    state_t            w_state_nx;
    logic              w_g_nx;
    logic              w_lg_nx;
    logic [31:0]       w_la_nx;
    logic [TC_W-1:0]   w_tc_nx;
    logic              w_cap;
    logic              w_err_inc;
    logic [1:0]        w_iwait_nx;
    logic              w_ramren_nx;
    logic              w_req_en;
    logic [31:0]       w_req_addr;

    // Only the granted CPU's request/address matter while in REQ
    assign w_req_en   = bus.iREN[r_g];
    assign w_req_addr = r_g ? bus.iaddr1 : bus.iaddr0;

    always_comb begin
        w_state_nx  = r_state;
        w_g_nx      = r_g;
        w_lg_nx     = r_lg;
        w_la_nx     = r_la;
        w_tc_nx     = r_tc;
        w_cap       = 1'b0;
        w_err_inc   = 1'b0;
        w_iwait_nx  = 2'b11;
        w_ramren_nx = 1'b0;

        case (r_state)
            IDLE: begin
                if (|bus.iREN) begin
                    w_state_nx = REQ;
                    w_g_nx     = (bus.iREN == 2'b11) ? ~r_lg : bus.iREN[1];
                    w_lg_nx    = w_g_nx;
                    w_la_nx    = w_g_nx ? bus.iaddr1 : bus.iaddr0;
                    w_tc_nx    = '0;
                end
            end
            REQ: begin
                // Withdrawal or redirect wins over any RAM response this cycle
                if (!w_req_en || (w_req_addr != r_la)) begin
                    w_state_nx = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    w_state_nx = RESP;
                    w_cap      = 1'b1;
                end else if (bus.ramstate == ERROR) begin
                    w_state_nx = IDLE;
                    w_err_inc  = 1'b1;
                end else if (r_tc == TC_LAST) begin
                    w_state_nx = IDLE;
                    w_err_inc  = 1'b1;
                end else begin
                    w_tc_nx = r_tc + TC_W'(1);
                end
            end
            RESP: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        if (w_state_nx == RESP) begin
            w_iwait_nx[r_g] = 1'b0;
        end
        w_ramren_nx = (w_state_nx == REQ);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_g      <= 1'b0;
            r_lg     <= 1'b1;
            r_la     <= '0;
            r_tc     <= '0;
            r_iload0 <= '0;
            r_iload1 <= '0;
            r_err    <= '0;
            r_iwait  <= 2'b11;
            r_ramren <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_g      <= w_g_nx;
            r_lg     <= w_lg_nx;
            r_la     <= w_la_nx;
            r_tc     <= w_tc_nx;
            r_iwait  <= w_iwait_nx;
            r_ramren <= w_ramren_nx;
            if (w_cap && !r_g) begin
                r_iload0 <= bus.ramload;
            end
            if (w_cap && r_g) begin
                r_iload1 <= bus.ramload;
            end
            if (w_err_inc && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end

    assign bus.iwait     = r_iwait;
    assign bus.ramREN    = r_ramren;
    assign bus.ramaddr   = r_la;
    assign bus.iload0    = r_iload0;
    assign bus.iload1    = r_iload1;
    assign bus.err_count = r_err;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed vector bench for imem_arbiter (TIMEOUT = 4).
module tb_imem_arbiter;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    imem_arbiter_if bus();

    imem_arbiter #(.TIMEOUT(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  iren;
        logic [31:0] a0;
        logic [31:0] a1;
        ramstate_t   rs;
        logic [31:0] ld;
        logic [1:0]  e_iwait;
        logic        e_ren;
        logic [31:0] e_addr;
        logic [31:0] e_ld0;
        logic [31:0] e_ld1;
        logic [7:0]  e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] en, input logic [31:0] a0,
                       input logic [31:0] a1, input ramstate_t rs, input logic [31:0] ld,
                       input logic [1:0] ew, input logic er, input logic [31:0] ea,
                       input logic [31:0] el0, input logic [31:0] el1, input logic [7:0] ee);
        vec_t v;
        v.rst = r; v.iren = en; v.a0 = a0; v.a1 = a1; v.rs = rs; v.ld = ld;
        v.e_iwait = ew; v.e_ren = er; v.e_addr = ea;
        v.e_ld0 = el0; v.e_ld1 = el1; v.e_err = ee;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, let one rising edge pass, then settle
    task automatic cyc(input logic r, input logic [1:0] en, input logic [31:0] a0,
                       input logic [31:0] a1, input ramstate_t rs, input logic [31:0] ld);
        @(negedge clk);
        rst          = r;
        bus.iREN     = en;
        bus.iaddr0   = a0;
        bus.iaddr1   = a1;
        bus.ramstate = rs;
        bus.ramload  = ld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iREN = 2'b00; bus.iaddr0 = '0; bus.iaddr1 = '0;
        bus.ramstate = FREE; bus.ramload = '0;

        // reset
        add(1'b1, 2'b00, 32'h0,  32'h0,   FREE,   32'h0,        2'b11, 1'b0, 32'h0,   32'h0,        32'h0,        8'd0);
        // single request, ACCESS on second REQ cycle
        add(1'b0, 2'b01, 32'h40, 32'h0,   FREE,   32'h0,        2'b11, 1'b1, 32'h40,  32'h0,        32'h0,        8'd0);
        add(1'b0, 2'b01, 32'h40, 32'h0,   BUSY,   32'h0,        2'b11, 1'b1, 32'h40,  32'h0,        32'h0,        8'd0);
        add(1'b0, 2'b01, 32'h40, 32'h0,   ACCESS, 32'hDEADBEEF, 2'b10, 1'b0, 32'h40,  32'hDEADBEEF, 32'h0,        8'd0);
        add(1'b0, 2'b00, 32'h40, 32'h0,   FREE,   32'h0,        2'b11, 1'b0, 32'h40,  32'hDEADBEEF, 32'h0,        8'd0);
        // redirect 0x40 -> 0x80
        add(1'b0, 2'b01, 32'h40, 32'h0,   FREE,   32'h0,        2'b11, 1'b1, 32'h40,  32'hDEADBEEF, 32'h0,        8'd0);
        add(1'b0, 2'b01, 32'h80, 32'h0,   BUSY,   32'h0,        2'b11, 1'b0, 32'h40,  32'hDEADBEEF, 32'h0,        8'd0);
        add(1'b0, 2'b01, 32'h80, 32'h0,   FREE,   32'h0,        2'b11, 1'b1, 32'h80,  32'hDEADBEEF, 32'h0,        8'd0);
        add(1'b0, 2'b01, 32'h80, 32'h0,   ACCESS, 32'h11111111, 2'b10, 1'b0, 32'h80,  32'h11111111, 32'h0,        8'd0);
        add(1'b0, 2'b00, 32'h80, 32'h0,   FREE,   32'h0,        2'b11, 1'b0, 32'h80,  32'h11111111, 32'h0,        8'd0);
        // CPU1: ERROR abort, then timeout after 4 REQ cycles
        add(1'b0, 2'b10, 32'h80, 32'h100, FREE,   32'h0,        2'b11, 1'b1, 32'h100, 32'h11111111, 32'h0,        8'd0);
        add(1'b0, 2'b10, 32'h80, 32'h100, ERROR,  32'h0,        2'b11, 1'b0, 32'h100, 32'h11111111, 32'h0,        8'd1);
        add(1'b0, 2'b10, 32'h80, 32'h100, FREE,   32'h0,        2'b11, 1'b1, 32'h100, 32'h11111111, 32'h0,        8'd1);
        add(1'b0, 2'b10, 32'h80, 32'h100, BUSY,   32'h0,        2'b11, 1'b1, 32'h100, 32'h11111111, 32'h0,        8'd1);
        add(1'b0, 2'b10, 32'h80, 32'h100, BUSY,   32'h0,        2'b11, 1'b1, 32'h100, 32'h11111111, 32'h0,        8'd1);
        add(1'b0, 2'b10, 32'h80, 32'h100, BUSY,   32'h0,        2'b11, 1'b1, 32'h100, 32'h11111111, 32'h0,        8'd1);
        add(1'b0, 2'b10, 32'h80, 32'h100, BUSY,   32'h0,        2'b11, 1'b0, 32'h100, 32'h11111111, 32'h0,        8'd2);
        add(1'b0, 2'b00, 32'h80, 32'h100, FREE,   32'h0,        2'b11, 1'b0, 32'h100, 32'h11111111, 32'h0,        8'd2);
        // abort beats ACCESS: request drop, then redirect
        add(1'b0, 2'b10, 32'h80, 32'h200, FREE,   32'h0,        2'b11, 1'b1, 32'h200, 32'h11111111, 32'h0,        8'd2);
        add(1'b0, 2'b00, 32'h80, 32'h200, ACCESS, 32'h00000BAD, 2'b11, 1'b0, 32'h200, 32'h11111111, 32'h0,        8'd2);
        add(1'b0, 2'b10, 32'h80, 32'h200, FREE,   32'h0,        2'b11, 1'b1, 32'h200, 32'h11111111, 32'h0,        8'd2);
        add(1'b0, 2'b10, 32'h80, 32'h204, ACCESS, 32'h00000BAD, 2'b11, 1'b0, 32'h200, 32'h11111111, 32'h0,        8'd2);
        add(1'b0, 2'b10, 32'h80, 32'h204, FREE,   32'h0,        2'b11, 1'b1, 32'h204, 32'h11111111, 32'h0,        8'd2);
        add(1'b0, 2'b10, 32'h80, 32'h204, ACCESS, 32'hCAFEF00D, 2'b01, 1'b0, 32'h204, 32'h11111111, 32'hCAFEF00D, 8'd2);
        add(1'b0, 2'b00, 32'h80, 32'h204, FREE,   32'h0,        2'b11, 1'b0, 32'h204, 32'h11111111, 32'hCAFEF00D, 8'd2);
        // reset during REQ with ACCESS
        add(1'b0, 2'b01, 32'h40, 32'h204, FREE,   32'h0,        2'b11, 1'b1, 32'h40,  32'h11111111, 32'hCAFEF00D, 8'd2);
        add(1'b1, 2'b01, 32'h40, 32'h204, ACCESS, 32'h12345678, 2'b11, 1'b0, 32'h0,   32'h0,        32'h0,        8'd0);
        add(1'b0, 2'b00, 32'h40, 32'h204, FREE,   32'h0,        2'b11, 1'b0, 32'h0,   32'h0,        32'h0,        8'd0);
        // contention: grants 0,1,0,1 with an idle cycle between; CPU1 address ignored while CPU0 granted
        add(1'b0, 2'b11, 32'hA0, 32'hB0,  ACCESS, 32'h0,        2'b11, 1'b1, 32'hA0,  32'h0,        32'h0,        8'd0);
        add(1'b0, 2'b11, 32'hA0, 32'hDEAD,ACCESS, 32'hA0A0,     2'b10, 1'b0, 32'hA0,  32'hA0A0,     32'h0,        8'd0);
        add(1'b0, 2'b11, 32'hA0, 32'hB0,  ACCESS, 32'h0,        2'b11, 1'b0, 32'hA0,  32'hA0A0,     32'h0,        8'd0);
        add(1'b0, 2'b11, 32'hA0, 32'hB0,  ACCESS, 32'h0,        2'b11, 1'b1, 32'hB0,  32'hA0A0,     32'h0,        8'd0);
        add(1'b0, 2'b11, 32'hA0, 32'hB0,  ACCESS, 32'hB0B0,     2'b01, 1'b0, 32'hB0,  32'hA0A0,     32'hB0B0,     8'd0);
        add(1'b0, 2'b11, 32'hA0, 32'hB0,  ACCESS, 32'h0,        2'b11, 1'b0, 32'hB0,  32'hA0A0,     32'hB0B0,     8'd0);
        add(1'b0, 2'b11, 32'hA0, 32'hB0,  ACCESS, 32'h0,        2'b11, 1'b1, 32'hA0,  32'hA0A0,     32'hB0B0,     8'd0);
        add(1'b0, 2'b11, 32'hA0, 32'hB0,  ACCESS, 32'hA1A1,     2'b10, 1'b0, 32'hA0,  32'hA1A1,     32'hB0B0,     8'd0);
        add(1'b0, 2'b11, 32'hA0, 32'hB0,  ACCESS, 32'h0,        2'b11, 1'b0, 32'hA0,  32'hA1A1,     32'hB0B0,     8'd0);
        add(1'b0, 2'b11, 32'hA0, 32'hB0,  ACCESS, 32'h0,        2'b11, 1'b1, 32'hB0,  32'hA1A1,     32'hB0B0,     8'd0);
        add(1'b0, 2'b11, 32'hA0, 32'hB0,  ACCESS, 32'hB1B1,     2'b01, 1'b0, 32'hB0,  32'hA1A1,     32'hB1B1,     8'd0);
        add(1'b0, 2'b00, 32'hA0, 32'hB0,  FREE,   32'h0,        2'b11, 1'b0, 32'hB0,  32'hA1A1,     32'hB1B1,     8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].iren, vecs[i].a0, vecs[i].a1, vecs[i].rs, vecs[i].ld);
            chk("iwait",     i, 32'(bus.iwait),     32'(vecs[i].e_iwait));
            chk("ramREN",    i, 32'(bus.ramREN),    32'(vecs[i].e_ren));
            chk("ramaddr",   i, bus.ramaddr,        vecs[i].e_addr);
            chk("iload0",    i, bus.iload0,         vecs[i].e_ld0);
            chk("iload1",    i, bus.iload1,         vecs[i].e_ld1);
            chk("err_count", i, 32'(bus.err_count), 32'(vecs[i].e_err));
        end

        // err_count saturation over 300 ERROR aborts
        cyc(1'b1, 2'b00, 32'h0, 32'h0, FREE, 32'h0);
        chk("sat_reset", 0, 32'(bus.err_count), 32'd0);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 2'b01, 32'h10, 32'h0, FREE,  32'h0);
            cyc(1'b0, 2'b01, 32'h10, 32'h0, ERROR, 32'h0);
            if (i == 0)   chk("sat_first", i, 32'(bus.err_count), 32'd1);
            if (i == 253) chk("sat_254",   i, 32'(bus.err_count), 32'd254);
            if (i == 254) chk("sat_255",   i, 32'(bus.err_count), 32'd255);
        end
        chk("sat_final",  300, 32'(bus.err_count), 32'd255);
        chk("sat_iwait",  300, 32'(bus.iwait),     32'h3);
        chk("sat_ramREN", 300, 32'(bus.ramREN),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
